// File: rtl/sc_pkg.sv
// sc_pkg: shared types, constants and helpers for the stochastic bitstream generator.
`include "sys_defs.svh"
package sc_pkg;
   localparam int BIN_LEN = `BIN_LEN;
   localparam int unsigned SEED_DEFAULT = 1;
   typedef enum logic {IDLE, STREAM} sc_gen_state_t;
   function automatic logic is_lockup_seed(input logic [31:0] seed, input int width);
      logic [31:0] mask;
      mask = (width >= 32) ? '1 : (32'd1 << width) - 32'd1;
      return (seed & mask) == mask;
   endfunction
   // Maximal-length tap masks; tap n of the classic tables sits at bit n-1.
   function automatic logic [31:0] lfsr_taps(input int width);
      case (width)
         3:       return 32'h0000_0006;
         4:       return 32'h0000_000C;
         5:       return 32'h0000_0014;
         6:       return 32'h0000_0030;
         7:       return 32'h0000_0060;
         9:       return 32'h0000_0110;
         10:      return 32'h0000_0240;
         11:      return 32'h0000_0500;
         12:      return 32'h0000_0829;
         13:      return 32'h0000_100D;
         14:      return 32'h0000_2015;
         15:      return 32'h0000_6000;
         16:      return 32'h0000_D008;
         default: return 32'h0000_00B8;
      endcase
   endfunction
endpackage

// File: rtl/lfsr.sv
// LFSR: Fibonacci XNOR shift register of maximal length; all-ones is the lock-up state.
module LFSR #(
   parameter int WIDTH = sc_pkg::BIN_LEN
) (
   input  logic             clock,
   input  logic             enable,
   input  logic             init,
   input  logic [WIDTH-1:0] init_val,
   output logic [WIDTH-1:0] out_val
);
   localparam logic [WIDTH-1:0] TAPS = WIDTH'(sc_pkg::lfsr_taps(WIDTH));
   logic [WIDTH-1:0] state_q, state_d;
   always_comb begin
      state_d = !enable ? state_q : init ? init_val : {state_q[WIDTH-2:0], ~^(state_q & TAPS)};
   end
   always_ff @(posedge clock) begin
      state_q <= state_d;
   end
   assign out_val = state_q;
endmodule

// File: rtl/sys_defs.svh
`ifndef SYS_DEFS_SVH
`define SYS_DEFS_SVH
`define BIN_LEN 8
`endif

// File: rtl/sc_bitstream_gen.sv
// sc_bitstream_gen: turns an unsigned operand into a unipolar stochastic bitstream
// by comparing it against a freshly seeded LFSR, counting the ones it emits.
module sc_bitstream_gen #(
   parameter int          BIN_LEN      = sc_pkg::BIN_LEN,
   parameter int unsigned SEED_DEFAULT = sc_pkg::SEED_DEFAULT
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [BIN_LEN-1:0] in_value,
   input  logic [BIN_LEN-1:0] in_seed,
   input  logic [BIN_LEN-1:0] in_len,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_bit,
   output logic               out_last,
   output logic [BIN_LEN-1:0] ones_count
);
   import sc_pkg::*;
   sc_gen_state_t state_q, state_d;
   logic [BIN_LEN-1:0] value_q, value_d, len_q, len_d, count_q, count_d, ones_q, ones_d;
   logic [BIN_LEN-1:0] lfsr_out, init_val;
   logic accept, fire, lfsr_en;
   LFSR #(.WIDTH(BIN_LEN)) u_lfsr (
      .clock    (clock),
      .enable   (lfsr_en),
      .init     (accept),
      .init_val (init_val),
      .out_val  (lfsr_out)
   );
   always_comb begin
      in_ready   = state_q == IDLE;
      out_valid  = state_q == STREAM;
      out_bit    = out_valid && (lfsr_out < value_q);
      out_last   = out_valid && (count_q == len_q - BIN_LEN'(1));
      ones_count = ones_q;
      accept     = in_valid && in_ready;
      fire       = out_valid && out_ready;
      lfsr_en    = accept || fire;
      init_val   = is_lockup_seed(32'(in_seed), BIN_LEN) ? BIN_LEN'(SEED_DEFAULT) : in_seed;
      state_d    = accept ? STREAM : (fire && out_last) ? IDLE : state_q;
      value_d    = accept ? in_value : value_q;
      len_d      = accept ? ((in_len == '0) ? '1 : in_len) : len_q;
      count_d    = accept ? '0 : fire ? count_q + BIN_LEN'(1) : count_q;
      ones_d     = accept ? '0 : fire ? ones_q + BIN_LEN'(out_bit) : ones_q;
   end
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         value_q <= '0;
         len_q   <= '0;
         count_q <= '0;
         ones_q  <= '0;
      end else begin
         state_q <= state_d;
         value_q <= value_d;
         len_q   <= len_d;
         count_q <= count_d;
         ones_q  <= ones_d;
      end
   end
endmodule

// File: tb/tb_sc_bitstream_gen.sv
// tb_sc_bitstream_gen: directed streams against a queue-based stream model.
module tb_sc_bitstream_gen;
   logic clock = 0, reset_n = 0, in_valid = 0, out_ready = 1, rnd = 0;
   logic [7:0] in_value = 0, in_seed = 0, in_len = 0;
   logic in_ready, out_valid, out_bit, out_last;
   logic [7:0] ones_count;
   int vectors = 0, errs = 0;
   bit busy = 0;
   bit bits [0:255];
   int idx = 0, m_len = 0, ones = 0;
   bit cap [$];
   bit cap_a [$];

   sc_bitstream_gen dut (
      .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_value(in_value), .in_seed(in_seed), .in_len(in_len), .out_valid(out_valid),
      .out_ready(out_ready), .out_bit(out_bit), .out_last(out_last), .ones_count(ones_count)
   );

   always #5 clock = ~clock;

   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      return {s[6:0], ~(s[7] ^ s[5] ^ s[4] ^ s[3])};
   endfunction

   task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
      end
   endtask

   // Stream model: the whole expected bit sequence is built at acceptance.
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         busy = 0;
         ones = 0;
         idx = 0;
      end else if (busy) begin
         if (out_ready) begin
            cap.push_back(out_bit);
            ones += int'(bits[idx]);
            idx++;
            if (idx == m_len) busy = 0;
         end
      end else if (in_valid) begin
         logic [7:0] s;
         m_len = (in_len == 0) ? 255 : int'(in_len);
         s = (in_seed == 8'hFF) ? 8'h01 : in_seed;
         for (int i = 0; i < m_len; i++) begin
            bits[i] = s < in_value;
            s = lfsr_next(s);
         end
         idx = 0;
         ones = 0;
         busy = 1;
         cap.delete();
      end
   end

   always @(negedge clock) begin
      check("in_ready", 32'(in_ready), 32'(!busy));
      check("out_valid", 32'(out_valid), 32'(busy));
      check("out_bit", 32'(out_bit), busy ? 32'(bits[idx]) : 32'd0);
      check("out_last", 32'(out_last), 32'(busy && idx == m_len - 1));
      check("ones_count", 32'(ones_count), 32'(ones));
   end

   always @(negedge clock) out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;

   task automatic req(input logic [7:0] v, input logic [7:0] s, input logic [7:0] l);
      @(negedge clock);
      in_valid = 1; in_value = v; in_seed = s; in_len = l;
      @(negedge clock);
      in_valid = 0;
   endtask

   task automatic wait_idle(output int k);
      k = 0;
      while (busy && k < 3000) begin
         @(negedge clock);
         k++;
      end
      if (busy) begin
         errs++;
         $display("FAIL timeout: stream still active after %0d cycles", k);
      end
   endtask

   initial begin
      int k;
      logic [7:0] s;
      logic [7:0] seq [6];
      seq = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1E, 8'h3D};
      s = 8'h01;
      for (int i = 0; i < 6; i++) begin
         check("model_seq", 32'(s), 32'(seq[i]));
         s = lfsr_next(s);
      end
      k = 1;
      s = lfsr_next(8'h01);
      while (s != 8'h01 && k < 300) begin s = lfsr_next(s); k++; end
      check("model_period", k, 255);
      check("model_lockup", 32'(lfsr_next(8'hFF)), 32'hFF);

      repeat (3) @(negedge clock);
      check("rst_in_ready", 32'(in_ready), 1);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_bit", 32'(out_bit), 0);
      check("rst_out_last", 32'(out_last), 0);
      check("rst_ones", 32'(ones_count), 0);
      reset_n = 1;

      req(8'd100, 8'h01, 8'd0);
      check("first_bit_latency", 32'(out_valid), 1);
      wait_idle(k);
      check("full_duration", k, 255);
      check("full_ones", 32'(ones_count), 100);
      check("full_ready_back", 32'(in_ready), 1);
      check("full_len", cap.size(), 255);

      req(8'd0, 8'h37, 8'd0);
      wait_idle(k);
      check("zero_ones", 32'(ones_count), 0);
      req(8'd255, 8'hC4, 8'd0);
      wait_idle(k);
      check("max_ones", 32'(ones_count), 255);

      rnd = 1;
      req(8'd128, 8'h5A, 8'd16);
      wait_idle(k);
      rnd = 0;
      check("bp_handshakes", cap.size(), 16);

      req(8'd60, 8'hFF, 8'd20);
      wait_idle(k);
      cap_a = cap;
      req(8'd60, 8'h01, 8'd20);
      wait_idle(k);
      check("lockup_len", cap_a.size(), 20);
      check("lockup_same", 32'(cap_a == cap), 1);
      for (int i = 0; i < 6; i++) check("lockup_head", 32'(cap_a[i]), (i < 5) ? 1 : 0);

      req(8'd200, 8'h33, 8'd0);
      k = 0;
      while (idx < 40 && k < 500) begin @(negedge clock); k++; end
      check("reached_bit40", idx, 40);
      #2 reset_n = 0;
      #1;
      check("arst_out_valid", 32'(out_valid), 0);
      check("arst_ones", 32'(ones_count), 0);
      check("arst_out_last", 32'(out_last), 0);
      check("arst_in_ready", 32'(in_ready), 1);
      repeat (2) @(negedge clock);
      reset_n = 1;
      @(negedge clock);
      check("post_rst_ready", 32'(in_ready), 1);
      req(8'd10, 8'h01, 8'd0);
      wait_idle(k);
      check("post_rst_ones", 32'(ones_count), 10);

      @(negedge clock);
      in_valid = 1; in_value = 8'd77; in_seed = 8'h09; in_len = 8'd8;
      @(negedge clock);
      in_value = 8'd250; in_seed = 8'h81; in_len = 8'd3;
      repeat (4) @(negedge clock);
      check("held_valid_busy", 32'(in_ready), 0);
      in_valid = 0;
      wait_idle(k);
      check("held_valid_len", cap.size(), 8);

      req(8'd200, 8'h01, 8'd1);
      check("single_valid", 32'(out_valid), 1);
      check("single_last", 32'(out_last), 1);
      check("single_bit", 32'(out_bit), 1);
      @(negedge clock);
      check("single_ready_back", 32'(in_ready), 1);
      check("single_ones", 32'(ones_count), 1);

      repeat (2) @(negedge clock);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule

// File: doc/sc_bitstream_gen.md
# sc_bitstream_gen

Stochastic number generator (SNG) stage that converts a `BIN_LEN`-bit binary operand into a unipolar stochastic bitstream. It seeds and steps an internal `LFSR` instance and compares the pseudo-random value against the operand each cycle, emitting `1` when `lfsr < value`. It sits between the binary operand source and the stochastic compute units. It also reports the number of ones emitted, for self-checking.

## Interface
- `BIN_LEN`: from `` `BIN_LEN `` in `sys_defs.svh`; operand, seed and LFSR width.
- `SEED_DEFAULT`, default `1`: seed substituted when the requested seed is the XNOR lock-up state, all ones.

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  operand request.
- `in_ready`  out  1  block can accept an operand.
- `in_value`  in  BIN_LEN  binary operand (unsigned).
- `in_seed`  in  BIN_LEN  LFSR seed for this stream.
- `in_len`  in  BIN_LEN  stream length in bits; `0` means 2^BIN_LEN−1.
- `out_valid`  out  1  `out_bit` valid.
- `out_ready`  in  1  consumer accepts the bit.
- `out_bit`  out  1  stochastic bit.
- `out_last`  out  1  current bit is the final bit of the stream.
- `ones_count`  out  BIN_LEN  ones emitted in the current or last stream.

## Operation
- FSM states:
  - `IDLE`: `in_ready=1`, `out_valid=0`.
  - `STREAM`: `in_ready=0`, `out_valid=1`.
- **`IDLE`→`STREAM`** on `in_valid && in_ready`. In that same cycle the block:
  - latches `value_q` and `len_q` (`0` maps to 2^BIN_LEN−1);
  - drives LFSR `enable=1`, `init=1`, with `init_val = (in_seed == all-ones) ? SEED_DEFAULT : in_seed`;
  - clears the bit counter and `ones_count`.
- **In `STREAM`:**
  - `out_bit = (lfsr_out < value_q)`, unsigned and combinational from registered state.
  - `out_last = (count == len_q−1)`.
- **On each `out_valid && out_ready`:**
  - LFSR `enable=1`, `init=0` (advances one step);
  - `count` increments;
  - `ones_count` increments by `out_bit`.
- **Stall:** when `out_ready=0`, LFSR enable, `count` and `ones_count` all hold. `out_bit` and `out_last` stay stable.
- **`STREAM`→`IDLE`** on the handshake with `out_last=1`.
- **`ones_count` hold:** keeps its final value in `IDLE` until the next acceptance.
- **`value_q == 0`:** all bits are `0`.
- **Full-length stream (2^BIN_LEN−1 bits):** the LFSR visits every non-all-ones state exactly once, so `ones_count == value_q` exactly.
- **Arithmetic:** counters are `BIN_LEN` bits with no overflow, because the maximum length is 2^BIN_LEN−1.
- **`in_valid` outside `IDLE`:** ignored; it is not queued.

## Timing
- **Reset values:**
  - `in_ready=1`, `out_valid=0`, `out_bit=0`, `out_last=0`, `ones_count=0`;
  - FSM in `IDLE`, `count=0`.
  - The LFSR has no reset; it is always reseeded on acceptance before use.
- **Latency:** acceptance in cycle T gives the first `out_valid` in cycle T+1.
- **Stream duration:** an N-bit stream with `out_ready` held high occupies cycles T+1..T+N. `in_ready` returns in T+N+1, so the throughput is one operand per N+1 cycles.
- **Reset mid-stream:**
  - outputs go to their reset values immediately (asynchronously);
  - after `reset_n` deasserts, the block is in `IDLE`;
  - the partial stream is discarded, with no `out_last`.
- **Single-bit stream:** with `in_len=1`, `out_last=1` on the first and only bit.

## Structure
- `sys_defs.svh` provides `` `BIN_LEN ``.
- Shared package `sc_pkg` holds:
  - the `sc_gen_state_t` enum (`IDLE`, `STREAM`);
  - the `SEED_DEFAULT` constant;
  - a helper function for the all-ones seed check.
- The only sub-module is one instance of the existing `LFSR` (ports `clock`, `enable`, `init`, `init_val`, `out_val`). Its enable and init are driven solely by this block's FSM.
- The comparator, counters and FSM are local logic.

## Test plan
All scenarios use BIN_LEN=8.
- **Full-length accuracy:** `value=100`, `seed=0x01`, `len=0` → 255 bits; `out_last` only on bit 255; `ones_count=100`; `in_ready` high the following cycle.
- **Extremes:**
  - `value=0`, `len=0` → 255 zeros, `ones_count=0`;
  - `value=255`, `len=0` → 255 ones, `ones_count=255`.
- **Backpressure:** `value=128`, `seed=0x5A`, `len=16`, with `out_ready` toggled pseudo-randomly → exactly 16 handshakes. The bit sequence matches a reference-model LFSR/comparator, and `out_bit` is stable during stalls.
- **Lock-up seed:** `seed=0xFF`, `value=60`, `len=20` → output identical to a run with `seed=SEED_DEFAULT`; the LFSR is never stuck.
- **Reset mid-stream:** assert `reset_n=0` at bit 40 of a 255-bit stream → `out_valid=0` and `ones_count=0` immediately, `in_ready=1` after release. A new `value=10`, `len=0` request then yields `ones_count=10`.
- **Ignored and single-bit requests:**
  - `in_valid` held high during `STREAM` → no second stream starts until `IDLE`;
  - `len=1` → one bit with `out_last=1`, `in_ready` back two cycles after acceptance.
